// File: rtl/pic_boot_pkg.sv
// Shared types and constants for the PIC boot path (UFM shadow loader and friends).
package pic_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_VALID,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [3:0] ROM_BE_ALL    = 4'hF;
  localparam logic [1:0] UFM_BURST_ONE = 2'd1;

endpackage

// File: rtl/ufm_rd_timeout.sv
// Per-word watchdog for UFM reads: reloads while idle, counts down while a read is in flight.
module ufm_rd_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= CW'(TIMEOUT);
    end else if (i_load) begin
      r_count <= CW'(TIMEOUT);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Fires on the TIMEOUT-th enabled cycle since the last reload.
  assign o_expired = i_en && (r_count <= CW'(1));

endmodule

// File: rtl/ufm_rom_shadow_loader.sv
// Copies the PIC image from UFM into the PIC RAM-as-ROM and holds the core in reset until done.
// Define UFM_SHADOW_CHECKSUM_EN to verify a trailing sum word before releasing the core.
module ufm_rom_shadow_loader
  import pic_boot_pkg::*;
#(
  parameter int WORDS      = 512,
  parameter int UFM_BASE   = 0,
  parameter int UFM_AW     = 16,
  parameter int ROM_AW     = 9,
  parameter int TIMEOUT    = 1023,
  parameter int AUTO_START = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic [UFM_AW-1:0] o_ufm_addr,
  output logic              o_ufm_read,
  output logic [1:0]        o_ufm_burstcount,
  input  logic [31:0]       i_ufm_readdata,
  input  logic              i_ufm_waitrequest,
  input  logic              i_ufm_readdatavalid,
  output logic [ROM_AW-1:0] o_rom_wr_addr,
  output logic [31:0]       o_rom_wr_data,
  output logic [3:0]        o_rom_wr_be,
  output logic              o_rom_wr_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_cpu_hold
);

  localparam int IW = ROM_AW + 1;
`ifdef UFM_SHADOW_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  loader_state_e     r_state;
  logic [IW-1:0]     r_index;
  logic              r_auto_arm;
  logic [UFM_AW-1:0] r_ufm_addr;
  logic              r_ufm_read;
  logic [ROM_AW-1:0] r_rom_addr;
  logic [31:0]       r_rom_data;
  logic [3:0]        r_rom_be;
  logic              r_rom_we;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_hold;

  logic              w_counting;
  logic              w_expired;
  logic              w_launch;
  logic              w_last_word;
  logic              w_sum_word;
  logic              w_sum_ok;
  logic [IW-1:0]     w_index_inc;

  assign w_counting  = (r_state == ST_REQ) || (r_state == ST_WAIT_VALID);
  assign w_index_inc = r_index + IW'(1);
  assign w_last_word = (r_index == IW'(WORDS - 1));
  assign w_launch    = ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR)) &&
                       (i_start || (r_auto_arm && (AUTO_START != 0)));

  ufm_rd_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_rd_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_load   (!w_counting),
    .i_en     (w_counting),
    .o_expired(w_expired)
  );

`ifdef UFM_SHADOW_CHECKSUM_EN
  logic [31:0] r_sum;
  logic [31:0] r_exp_sum;

  assign w_sum_word = (r_index == IW'(WORDS));
  assign w_sum_ok   = (r_sum == r_exp_sum);

  // The word just past the image is the expected sum; it is captured, never written to ROM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum     <= '0;
      r_exp_sum <= '0;
    end else if (w_launch) begin
      r_sum <= '0;
    end else if ((r_state == ST_WAIT_VALID) && i_ufm_readdatavalid) begin
      if (w_sum_word) begin
        r_exp_sum <= i_ufm_readdata;
      end else begin
        r_sum <= r_sum + i_ufm_readdata;
      end
    end
  end
`else
  assign w_sum_word = 1'b0;
  assign w_sum_ok   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_auto_arm <= 1'b1;
      r_ufm_addr <= '0;
      r_ufm_read <= 1'b0;
      r_rom_addr <= '0;
      r_rom_data <= '0;
      r_rom_be   <= '0;
      r_rom_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_hold     <= 1'b1;
    end else begin
      r_rom_we   <= 1'b0;
      r_rom_be   <= '0;
      r_auto_arm <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (w_launch) begin
            r_state    <= ST_REQ;
            r_index    <= '0;
            r_ufm_addr <= UFM_AW'(UFM_BASE);
            r_ufm_read <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_hold     <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!i_ufm_waitrequest) begin
            r_ufm_read <= 1'b0;
            r_state    <= ST_WAIT_VALID;
          end else if (w_expired) begin
            r_ufm_read <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
            r_state    <= ST_ERROR;
          end
        end
        // Data arriving on the final timeout cycle still counts as a good read.
        ST_WAIT_VALID: begin
          if (i_ufm_readdatavalid) begin
            if (w_sum_word) begin
              r_state <= ST_CHECK;
            end else begin
              r_rom_addr <= r_index[ROM_AW-1:0];
              r_rom_data <= i_ufm_readdata;
              r_rom_be   <= ROM_BE_ALL;
              r_rom_we   <= 1'b1;
              r_state    <= ST_WRITE;
            end
          end else if (w_expired) begin
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_state <= ST_ERROR;
          end
        end
        ST_WRITE: begin
          if (w_last_word && !CHECKSUM_EN) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hold  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_index    <= w_index_inc;
            r_ufm_addr <= UFM_AW'(UFM_BASE) + UFM_AW'(w_index_inc);
            r_ufm_read <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_CHECK: begin
          r_busy <= 1'b0;
          if (w_sum_ok) begin
            r_done  <= 1'b1;
            r_hold  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_error <= 1'b1;
            r_state <= ST_ERROR;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ufm_addr       = r_ufm_addr;
  assign o_ufm_read       = r_ufm_read;
  assign o_ufm_burstcount = UFM_BURST_ONE;
  assign o_rom_wr_addr    = r_rom_addr;
  assign o_rom_wr_data    = r_rom_data;
  assign o_rom_wr_be      = r_rom_be;
  assign o_rom_wr_we      = r_rom_we;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_error          = r_error;
  assign o_cpu_hold       = r_hold;

endmodule

// File: tb/tb_ufm_rom_shadow_loader.sv
// Scoreboard bench for ufm_rom_shadow_loader: random-latency UFM model, expected reads/writes queued per copy.
// Honours UFM_SHADOW_CHECKSUM_EN when the design is built with it.
module tb_ufm_rom_shadow_loader;

  localparam int WORDS    = 4;
  localparam int UFM_BASE = 16;
  localparam int UFM_AW   = 16;
  localparam int ROM_AW   = 9;
  localparam int TIMEOUT  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_start = 1'b0;
  logic [UFM_AW-1:0] o_ufm_addr;
  logic              o_ufm_read;
  logic [1:0]        o_ufm_burstcount;
  logic [31:0]       i_ufm_readdata = '0;
  logic              i_ufm_waitrequest = 1'b1;
  logic              i_ufm_readdatavalid = 1'b0;
  logic [ROM_AW-1:0] o_rom_wr_addr;
  logic [31:0]       o_rom_wr_data;
  logic [3:0]        o_rom_wr_be;
  logic              o_rom_wr_we;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic              o_cpu_hold;

  always #5 clk = ~clk;

  ufm_rom_shadow_loader #(
    .WORDS(WORDS), .UFM_BASE(UFM_BASE), .UFM_AW(UFM_AW),
    .ROM_AW(ROM_AW), .TIMEOUT(TIMEOUT), .AUTO_START(1)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .o_ufm_addr(o_ufm_addr), .o_ufm_read(o_ufm_read), .o_ufm_burstcount(o_ufm_burstcount),
    .i_ufm_readdata(i_ufm_readdata), .i_ufm_waitrequest(i_ufm_waitrequest),
    .i_ufm_readdatavalid(i_ufm_readdatavalid),
    .o_rom_wr_addr(o_rom_wr_addr), .o_rom_wr_data(o_rom_wr_data), .o_rom_wr_be(o_rom_wr_be),
    .o_rom_wr_we(o_rom_wr_we), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_cpu_hold(o_cpu_hold)
  );

  typedef struct {
    logic [ROM_AW-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               expWr[$];
  logic [UFM_AW-1:0] expRd[$];
  logic [31:0]       mem [0:63];

  int checksTotal = 0;
  int checksPassed = 0;
  int wrSeen = 0;
  int busyCycles = 0;

  // Flash model knobs and state
  int                holdLeft = -1;
  int                latLeft = 0;
  bit                pend = 1'b0;
  logic [31:0]       pendData = '0;
  logic [UFM_AW-1:0] holdAddr = '0;
  int                forceWait = -1;
  logic [UFM_AW-1:0] forceAddr = '0;
  int                maxWait = 3;
  int                minLat = 1;
  int                maxLat = 3;
  bit                noValid = 1'b0;
  bit                spurEn = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor first (ROM writes, busy time), then the UFM slave drives inputs for the next rising edge.
  always @(negedge clk) begin : flashModel
    wr_t e;
    if (o_busy) busyCycles++;
    if (o_rom_wr_we) begin
      wrSeen++;
      if (expWr.size() == 0) begin
        checkOutput("rom_wr_unexpected", 64'd1, 64'd0);
      end else begin
        e = expWr.pop_front();
        checkOutput("rom_wr_addr", 64'(o_rom_wr_addr), 64'(e.addr));
        checkOutput("rom_wr_data", 64'(o_rom_wr_data), 64'(e.data));
        checkOutput("rom_wr_be", 64'(o_rom_wr_be), 64'hF);
      end
    end

    i_ufm_readdatavalid = 1'b0;
    if (reset) begin
      pend = 1'b0;
      holdLeft = -1;
      i_ufm_waitrequest = 1'b1;
    end else begin
      if (pend) begin
        latLeft--;
        if (latLeft == 0) begin
          i_ufm_readdatavalid = 1'b1;
          i_ufm_readdata = pendData;
          pend = 1'b0;
        end
      end else if (spurEn && ($urandom_range(0, 3) == 0)) begin
        i_ufm_readdatavalid = 1'b1;
        i_ufm_readdata = $urandom;
      end

      if (o_ufm_read) begin
        if (holdLeft < 0) begin
          holdLeft = (forceWait >= 0 && o_ufm_addr == forceAddr) ? forceWait : $urandom_range(0, maxWait);
          holdAddr = o_ufm_addr;
        end else begin
          checkOutput("ufm_addr_stable", 64'(o_ufm_addr), 64'(holdAddr));
        end
        if (holdLeft > 0) begin
          i_ufm_waitrequest = 1'b1;
          holdLeft--;
        end else begin
          i_ufm_waitrequest = 1'b0;
          holdLeft = -1;
          if (expRd.size() == 0) checkOutput("ufm_read_unexpected", 64'd1, 64'd0);
          else checkOutput("ufm_read_addr", 64'(o_ufm_addr), 64'(expRd.pop_front()));
          checkOutput("ufm_burstcount", 64'(o_ufm_burstcount), 64'd1);
          if (!noValid) begin
            pend = 1'b1;
            latLeft = $urandom_range(minLat, maxLat);
            pendData = mem[o_ufm_addr[5:0]];
          end
        end
      end else begin
        if (holdLeft >= 0) begin
          checkOutput("ufm_read_dropped_while_waiting", 64'd0, 64'd1);
          holdLeft = -1;
        end
        i_ufm_waitrequest = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic loadImage(input bit pattern);
    for (int a = 0; a < 64; a++) mem[a] = pattern ? (32'(a) * 32'h11111111) : $urandom;
  endtask

  // Expected traffic for one full copy: every image word read in order and written to ROM index i.
  task automatic pushExpected(input bit badSum, output bit expErr);
    wr_t e;
    expErr = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      expRd.push_back(UFM_AW'(UFM_BASE + i));
      e.addr = ROM_AW'(i);
      e.data = mem[UFM_BASE + i];
      expWr.push_back(e);
    end
`ifdef UFM_SHADOW_CHECKSUM_EN
    begin
      logic [31:0] sum;
      sum = '0;
      for (int i = 0; i < WORDS; i++) sum += mem[UFM_BASE + i];
      mem[UFM_BASE + WORDS] = badSum ? (sum ^ (32'h1 << $urandom_range(0, 31))) : sum;
      expRd.push_back(UFM_AW'(UFM_BASE + WORDS));
      expErr = badSum;
    end
`else
    if (badSum) $display("[TB] checksum option not built, treating run as plain copy");
`endif
  endtask

  task automatic pulseStart(input string tag);
    @(posedge clk); #2 i_start = 1'b1;
    @(posedge clk); #2 i_start = 1'b0;
    checkOutput({tag, "_restart_hold"}, 64'(o_cpu_hold), 64'd1);
    checkOutput({tag, "_restart_done"}, 64'(o_done), 64'd0);
    checkOutput({tag, "_restart_busy"}, 64'(o_busy), 64'd1);
  endtask

  task automatic waitFinish(input string tag, input bit pokeStart, input int budget);
    bit finished;
    finished = 1'b0;
    for (int c = 0; c < budget && !finished; c++) begin
      @(posedge clk); #2;
      if (o_done || o_error) finished = 1'b1;
      else i_start = pokeStart && ($urandom_range(0, 5) == 0);
    end
    i_start = 1'b0;
    checkOutput({tag, "_finished"}, 64'(finished), 64'd1);
  endtask

  // One complete copy, started either by releasing reset (auto start) or by an i_start pulse.
  task automatic applyStimulus(input string tag, input bit viaReset, input bit badSum, input bit pokeStart);
    bit expErr;
    pushExpected(badSum, expErr);
    wrSeen = 0;
    if (viaReset) begin
      @(posedge clk); #2 reset = 1'b0;
    end else begin
      pulseStart(tag);
    end
    waitFinish(tag, pokeStart, 300);
    checkOutput({tag, "_done"}, 64'(o_done), 64'(!expErr));
    checkOutput({tag, "_error"}, 64'(o_error), 64'(expErr));
    checkOutput({tag, "_cpu_hold"}, 64'(o_cpu_hold), 64'(expErr));
    checkOutput({tag, "_busy"}, 64'(o_busy), 64'd0);
    checkOutput({tag, "_rom_writes"}, 64'(wrSeen), 64'(WORDS));
    checkOutput({tag, "_reads_left"}, 64'(expRd.size()), 64'd0);
    expWr.delete();
    expRd.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ufm_addr"}, 64'(o_ufm_addr), 64'd0);
    checkOutput({tag, "_ufm_read"}, 64'(o_ufm_read), 64'd0);
    checkOutput({tag, "_burstcount"}, 64'(o_ufm_burstcount), 64'd1);
    checkOutput({tag, "_rom_addr"}, 64'(o_rom_wr_addr), 64'd0);
    checkOutput({tag, "_rom_data"}, 64'(o_rom_wr_data), 64'd0);
    checkOutput({tag, "_rom_be"}, 64'(o_rom_wr_be), 64'd0);
    checkOutput({tag, "_rom_we"}, 64'(o_rom_wr_we), 64'd0);
    checkOutput({tag, "_busy"}, 64'(o_busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(o_done), 64'd0);
    checkOutput({tag, "_error"}, 64'(o_error), 64'd0);
    checkOutput({tag, "_cpu_hold"}, 64'(o_cpu_hold), 64'd1);
  endtask

  // Word 0 is accepted but never answered; the copy must give up after TIMEOUT cycles busy.
  task automatic timeoutRun();
    noValid = 1'b1;
    spurEn = 1'b0;
    expRd.push_back(UFM_AW'(UFM_BASE));
    wrSeen = 0;
    busyCycles = 0;
    pulseStart("timeout");
    waitFinish("timeout", 1'b0, 100);
    checkOutput("timeout_error", 64'(o_error), 64'd1);
    checkOutput("timeout_done", 64'(o_done), 64'd0);
    checkOutput("timeout_cpu_hold", 64'(o_cpu_hold), 64'd1);
    checkOutput("timeout_busy_cycles", 64'(busyCycles), 64'(TIMEOUT));
    checkOutput("timeout_rom_writes", 64'(wrSeen), 64'd0);
    checkOutput("timeout_reads_left", 64'(expRd.size()), 64'd0);
    expRd.delete();
    noValid = 1'b0;
  endtask

  // Reset lands while word 1 is outstanding; nothing further may be read or written.
  task automatic midResetRun();
    bit expErr;
    bit seen;
    minLat = 3;
    maxLat = 3;
    spurEn = 1'b0;
    pushExpected(1'b0, expErr);
    wrSeen = 0;
    pulseStart("midreset");
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin @(posedge clk); #2; seen = (wrSeen == 1); end
    checkOutput("midreset_word0_written", 64'(seen), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin seen = o_ufm_read; if (!seen) begin @(posedge clk); #2; end end
    checkOutput("midreset_word1_read", 64'(seen), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(posedge clk); #2; seen = !o_ufm_read; end
    checkOutput("midreset_word1_accepted", 64'(seen), 64'd1);
    reset = 1'b1;
    expWr.delete();
    expRd.delete();
    @(posedge clk); #2;
    checkResetState("midreset");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("midreset_no_more_writes", 64'(wrSeen), 64'd1);
    minLat = 1;
    maxLat = 3;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting ufm_rom_shadow_loader bench");
    repeat (4) @(posedge clk);
    #2;
    checkResetState("reset");

    loadImage(1'b1);
    applyStimulus("auto_pattern", 1'b1, 1'b0, 1'b0);

    spurEn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      loadImage(1'b0);
      applyStimulus($sformatf("rand%0d", r), 1'b0, 1'b0, 1'b1);
    end

    loadImage(1'b0);
    forceAddr = UFM_AW'(UFM_BASE + 2);
    forceWait = 5;
    minLat = 1;
    maxLat = 1;
    applyStimulus("wait5", 1'b0, 1'b0, 1'b0);
    forceWait = -1;
    maxLat = 3;

    timeoutRun();

    spurEn = 1'b1;
    loadImage(1'b0);
    applyStimulus("recover", 1'b0, 1'b0, 1'b1);

    loadImage(1'b1);
    midResetRun();
    spurEn = 1'b1;
    applyStimulus("after_reset", 1'b1, 1'b0, 1'b0);

`ifdef UFM_SHADOW_CHECKSUM_EN
    loadImage(1'b0);
    applyStimulus("bad_sum", 1'b0, 1'b1, 1'b0);
    loadImage(1'b0);
    applyStimulus("good_sum", 1'b0, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
